// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the register-file writeback scheduler.
package rf_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) c = c + {{ADDR_W{1'b0}}, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/rf_rr_arb2.sv
// rf_rr_arb2: 2-way round-robin arbiter with combinational grants.
// Ports: clk, rst_n (async active-low); req0/req1 requests in; gnt0/gnt1 one-hot grants out.
// On a tie the requester that did not win last time is granted.
module rf_rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    logic last_q, last_d;

    always_comb begin
        gnt0   = req0 && (!req1 || last_q == REQ_MEM);
        gnt1   = req1 && (!req0 || last_q == REQ_ALU);
        last_d = gnt0 ? REQ_ALU : gnt1 ? REQ_MEM : last_q;
    end

    // Reset to REQ_MEM so the ALU wins the first tie.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_q <= REQ_MEM;
        else        last_q <= last_d;
endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: arbitrates the register-file write port between ALU and memory writeback,
// tracks outstanding writes in a busy-bit scoreboard and flags RAW hazards on the read ports.
// Ports: clk, rst_n (async active-low); iss_valid/iss_addr reserve a destination;
// reqN_valid/addr/data in, reqN_ready out for ALU (0) and memory (1);
// rd_a_addr/rd_b_addr read addresses, hazard out; wr_load/wr_addr/wr_data drive the
// register file; busy_cnt counts busy registers; err is a sticky unexpected-write flag.
module rf_wb_scheduler
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic              hazard,
    output logic              wr_load,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              err
);
    logic                gnt0, gnt1;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_data;
    logic [NUM_REGS-1:0] set_v, clr_v;

    logic                wr_load_q, wr_load_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                err_q, err_d;

    rf_rr_arb2 u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req0 (req0_valid),
        .req1 (req1_valid),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    always_comb begin
        g_addr    = gnt1 ? req1_addr : req0_addr;
        g_data    = gnt1 ? req1_data : req0_data;
        // Writes to register 0 are accepted and sunk without pulsing Load.
        wr_load_d = (gnt0 || gnt1) && g_addr != REG_ZERO;
        wr_addr_d = (gnt0 || gnt1) ? g_addr : wr_addr_q;
        wr_data_d = (gnt0 || gnt1) ? g_data : wr_data_q;
        set_v     = '0;
        clr_v     = '0;
        if (iss_valid && iss_addr != REG_ZERO) set_v[iss_addr] = 1'b1;
        // Clear at the edge that ends the write cycle; a same-edge issue re-sets it.
        if (wr_load_q) clr_v[wr_addr_q] = 1'b1;
        busy_d    = (busy_q & ~clr_v) | set_v;
        cnt_d     = popcount(busy_d);
        err_d     = err_q || (wr_load_q && !busy_q[wr_addr_q]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_load_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_load_q <= wr_load_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign hazard     = busy_q[rd_a_addr] || busy_q[rd_b_addr];
    assign wr_load    = wr_load_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy_cnt   = cnt_q;
    assign err        = err_q;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed self-checking bench for rf_wb_scheduler.
module tb_rf_wb_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [3:0]  iss_addr;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr, req1_addr;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [3:0]  rd_a_addr, rd_b_addr;
    logic        hazard, wr_load, err;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .hazard(hazard),
        .wr_load(wr_load), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_cnt(busy_cnt), .err(err)
    );

    // Advance to 1 time unit after the next rising edge; inputs change and outputs are sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; iss_valid = 0; iss_addr = 0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        rd_a_addr = 0; rd_b_addr = 0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (wr_load !== 1'b0) begin errors++; $display("FAIL reset_wr_load got=%b exp=0", wr_load); end
        checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0000", wr_data); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (wr_load !== 1'b0 || hazard !== 1'b0 || busy_cnt !== 5'd0 || err !== 1'b0) begin
                errors++;
                $display("FAIL idle_%0d got wr_load=%b hazard=%b busy_cnt=%0d err=%b exp 0/0/0/0", i, wr_load, hazard, busy_cnt, err);
            end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        step();
        rd_a_addr = 4'd5; iss_valid = 1; iss_addr = 4'd5;
        step();
        iss_valid = 0;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL single_hazard_issued got=%b exp=1", hazard); end
        checks++; if (busy_cnt !== 5'd1) begin errors++; $display("FAIL single_cnt_issued got=%0d exp=1", busy_cnt); end
        req0_valid = 1; req0_addr = 4'd5; req0_data = 16'h1234;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got=%b exp=0", req1_ready); end
        step();
        req0_valid = 0;
        checks++; if (wr_load !== 1'b1 || wr_addr !== 4'd5 || wr_data !== 16'h1234) begin errors++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/1234", wr_load, wr_addr, wr_data); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL single_hazard_wcycle got=%b exp=1", hazard); end
        checks++; if (busy_cnt !== 5'd1) begin errors++; $display("FAIL single_cnt_wcycle got=%0d exp=1", busy_cnt); end
        step();
        checks++; if (wr_load !== 1'b0) begin errors++; $display("FAIL single_wr_load_after got=%b exp=0", wr_load); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL single_hazard_after got=%b exp=0", hazard); end
        checks++; if (busy_cnt !== 5'd0) begin errors++; $display("FAIL single_cnt_after got=%0d exp=0", busy_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", err); end
    endtask

    task automatic test_contention();
        logic [3:0]  ea;
        logic [15:0] ed;
        do_reset();
        step();
        req0_valid = 1; req0_addr = 4'd1; req0_data = 16'hAAAA;
        req1_valid = 1; req1_addr = 4'd2; req1_data = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL contend_grant_%0d got=%b%b exp=%b%b", k, req0_ready, req1_ready, k % 2 == 0, k % 2 == 1);
            end
            step();
            if (k == 3) begin req0_valid = 0; req1_valid = 0; end
            ea = (k % 2 == 0) ? 4'd1 : 4'd2;
            ed = (k % 2 == 0) ? 16'hAAAA : 16'h5555;
            checks++;
            if (wr_load !== 1'b1 || wr_addr !== ea || wr_data !== ed) begin
                errors++;
                $display("FAIL contend_write_%0d got=%b/%0d/%h exp=1/%0d/%h", k, wr_load, wr_addr, wr_data, ea, ed);
            end
        end
        step();
        checks++; if (wr_load !== 1'b0) begin errors++; $display("FAIL contend_end got=%b exp=0", wr_load); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        step();
        iss_valid = 1; iss_addr = 4'd0; rd_b_addr = 4'd0;
        step();
        iss_valid = 0;
        checks++; if (busy_cnt !== 5'd0) begin errors++; $display("FAIL r0_cnt got=%0d exp=0", busy_cnt); end
        req1_valid = 1; req1_addr = 4'd0; req1_data = 16'hFFFF;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got=%b exp=1", req1_ready); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL r0_hazard got=%b exp=0", hazard); end
        step();
        req1_valid = 0;
        checks++; if (wr_load !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 16'hFFFF) begin errors++; $display("FAIL r0_write got=%b/%0d/%h exp=0/0/ffff", wr_load, wr_addr, wr_data); end
        checks++; if (hazard !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL r0_after got hazard=%b err=%b exp=0/0", hazard, err); end
    endtask

    task automatic test_set_clear();
        do_reset();
        step();
        rd_a_addr = 4'd3; iss_valid = 1; iss_addr = 4'd3;
        step();
        iss_valid = 0;
        req0_valid = 1; req0_addr = 4'd3; req0_data = 16'h0BEE;
        step();
        req0_valid = 0;
        iss_valid = 1; iss_addr = 4'd3;
        checks++; if (wr_load !== 1'b1 || wr_addr !== 4'd3) begin errors++; $display("FAIL sc_write got=%b/%0d exp=1/3", wr_load, wr_addr); end
        step();
        iss_valid = 0;
        checks++; if (busy_cnt !== 5'd1) begin errors++; $display("FAIL sc_cnt got=%0d exp=1", busy_cnt); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sc_hazard got=%b exp=1", hazard); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sc_err got=%b exp=0", err); end
        // Issue to an already-busy register leaves the count unchanged.
        iss_valid = 1; iss_addr = 4'd3;
        step();
        iss_valid = 0;
        checks++; if (busy_cnt !== 5'd1) begin errors++; $display("FAIL waw_cnt got=%0d exp=1", busy_cnt); end
    endtask

    task automatic test_error();
        do_reset();
        step();
        req0_valid = 1; req0_addr = 4'd7; req0_data = 16'h0001;
        step();
        req0_valid = 0;
        checks++; if (wr_load !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL err_write got wr_load=%b err=%b exp=1/0", wr_load, err); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err); end
        step(); step(); step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        do_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reset got=%b exp=0", err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        iss_valid = 1; iss_addr = 4'd4;
        step();
        iss_valid = 0;
        req0_valid = 1; req0_addr = 4'd4; req0_data = 16'hCAFE;
        step();
        req0_valid = 0;
        checks++; if (wr_load !== 1'b1) begin errors++; $display("FAIL ar_pre got=%b exp=1", wr_load); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wr_load !== 1'b0) begin errors++; $display("FAIL ar_wr_load got=%b exp=0", wr_load); end
        checks++; if (busy_cnt !== 5'd0) begin errors++; $display("FAIL ar_cnt got=%0d exp=0", busy_cnt); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_reg_zero();
        test_set_clear();
        test_error();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
